hp_au_issue: RTL

Upstream issue stage for the parameterized HP-AU arithmetic unit (`hp_au_top`). It buffers tagged commands in a small FIFO and presents the head entry to the unit's combinational `a`/`b`/`sel` inputs. It captures the returned `result` with its tag into an output register, with valid/ready handshakes on both sides. Sustained throughput is one operation per clock.

---
 rtl/hp_au_issue_if.sv | 33 +++
 rtl/hp_au_issue.sv | 101 ++++++++++
 2 files changed

// File: rtl/hp_au_issue_if.sv
// Handshake and ALU-link bundle for the HP-AU issue stage.
// master = command producer / result consumer / ALU side; slave = the issue stage.
interface hp_au_issue_if #(
  parameter int WIDTH = 4,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [3:0]       in_sel;
  logic [TAG_W-1:0] in_tag;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_sel;
  logic [WIDTH-1:0] alu_result;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_a, in_b, in_sel, in_tag, alu_result, out_ready,
    input  in_ready, alu_a, alu_b, alu_sel, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sel, in_tag, alu_result, out_ready,
    output in_ready, alu_a, alu_b, alu_sel, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/hp_au_issue.sv
// Issue stage for hp_au_top: tagged command FIFO feeding the combinational unit,
// with a one-entry result register on the output side. One operation per clock.
module hp_au_issue #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  hp_au_issue_if.slave           bus,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            op_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_a   [DEPTH];
  logic [WIDTH-1:0] mem_b   [DEPTH];
  logic [3:0]       mem_sel [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          not_empty;
  logic          push;
  logic          pop;

  // Full/empty come from level alone, so ready never sees a same-cycle pop.
  assign not_empty    = (level != '0);
  assign bus.in_ready = (level != FULL);
  assign push         = bus.in_valid && bus.in_ready && !flush;
  assign pop          = not_empty && (!bus.out_valid || bus.out_ready) && !flush;

  always_comb begin
    bus.alu_a   = '0;
    bus.alu_b   = '0;
    bus.alu_sel = '0;
    if (not_empty) begin
      bus.alu_a   = mem_a[rd_ptr];
      bus.alu_b   = mem_b[rd_ptr];
      bus.alu_sel = mem_sel[rd_ptr];
    end
  end

  // Storage needs no reset; level guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]   <= bus.in_a;
      mem_b[wr_ptr]   <= bus.in_b;
      mem_sel[wr_ptr] <= bus.in_sel;
      mem_tag[wr_ptr] <= bus.in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Result register: a pop refills it, otherwise an accepted result empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid  <= 1'b0;
      bus.out_result <= '0;
      bus.out_tag    <= '0;
    end else if (flush) begin
      bus.out_valid <= 1'b0;
    end else if (pop) begin
      bus.out_valid  <= 1'b1;
      bus.out_result <= bus.alu_result;
      bus.out_tag    <= mem_tag[rd_ptr];
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (pop && (op_count != 16'hFFFF)) begin
      op_count <= op_count + 16'd1;
    end
  end
endmodule
